// File: rtl/obi_manager_bridge_if.sv
// rtl/obi_manager_bridge_if.sv - controller command/response and OBI manager signal bundle
interface obi_manager_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic                  cmd_we_i;
    logic [BE_WIDTH-1:0]   cmd_be_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    logic                  obi_req_o;
    logic                  obi_gnt_i;
    logic [ADDR_WIDTH-1:0] obi_addr_o;
    logic                  obi_we_o;
    logic [BE_WIDTH-1:0]   obi_be_o;
    logic [DATA_WIDTH-1:0] obi_wdata_o;

    logic                  obi_rvalid_i;
    logic                  obi_rready_o;
    logic [DATA_WIDTH-1:0] obi_rdata_i;
    logic                  obi_err_i;

    logic [15:0]           txn_count_o;
    logic                  proto_err_o;

    // Bridge side.
    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_gnt_i,
        input  obi_rvalid_i, obi_rdata_i, obi_err_i,
        output obi_rready_o,
        output txn_count_o, proto_err_o
    );

    // Controller plus OBI subordinate side.
    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_gnt_i,
        output obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  obi_rready_o,
        input  txn_count_o, proto_err_o
    );
endinterface

// File: rtl/obi_manager_bridge.sv
// rtl/obi_manager_bridge.sv - single-outstanding controller-to-OBI manager bridge
module obi_manager_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    obi_manager_bridge_if.master  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] LOCAL_ERR_DATA = DATA_WIDTH'(32'hBADCAB1E);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t                state;
    logic                  cmd_ready_q;
    logic                  req_q;
    logic                  rready_q;
    logic                  rsp_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [15:0]           count_q;
    logic                  proto_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            req_q       <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
            proto_q     <= 1'b0;
        end else begin
            // Stray handshakes are flagged but never advance the FSM.
            if ((bus.obi_gnt_i && state != ADDR) || (bus.obi_rvalid_i && state != RESP)) begin
                proto_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        addr_q      <= bus.cmd_addr_i;
                        we_q        <= bus.cmd_we_i;
                        be_q        <= bus.cmd_be_i;
                        wdata_q     <= bus.cmd_we_i ? bus.cmd_wdata_i : '0;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_addr_i[1:0] != 2'b00 || bus.cmd_be_i == '0) begin
                            rdata_q     <= LOCAL_ERR_DATA;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            req_q <= 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (bus.obi_gnt_i) begin
                        req_q    <= 1'b0;
                        rready_q <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.obi_rvalid_i) begin
                        rdata_q     <= we_q ? '0 : bus.obi_rdata_i;
                        err_q       <= bus.obi_err_i;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        count_q     <= count_q + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o  = cmd_ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.obi_req_o    = req_q;
    assign bus.obi_addr_o   = addr_q;
    assign bus.obi_we_o     = we_q;
    assign bus.obi_be_o     = be_q;
    assign bus.obi_wdata_o  = wdata_q;
    assign bus.obi_rready_o = rready_q;
    assign bus.txn_count_o  = count_q;
    assign bus.proto_err_o  = proto_q;
endmodule

// File: tb/tb_obi_manager_bridge.sv
// tb/tb_obi_manager_bridge.sv - directed self-checking bench for obi_manager_bridge
module tb_obi_manager_bridge;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] mem [0:15];

    obi_manager_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_manager_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_addr_i   = '0;
        bus.cmd_we_i     = 1'b0;
        bus.cmd_be_i     = '0;
        bus.cmd_wdata_i  = '0;
        bus.rsp_ready_i  = 1'b0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_cmd(input logic [31:0] addr, input logic we,
                             input logic [3:0] be, input logic [31:0] wdata);
        bus.cmd_addr_i  = addr;
        bus.cmd_we_i    = we;
        bus.cmd_be_i    = be;
        bus.cmd_wdata_i = wdata;
        bus.cmd_valid_i = 1'b1;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_wdata_i = 32'hFFFF_FFFF;
    endtask

    // Minimal subordinate: grant now, respond on the following cycle.
    task automatic serve(input logic err);
        logic [3:0] idx;
        idx = bus.obi_addr_o[5:2];
        if (bus.obi_we_o) mem[idx] = bus.obi_wdata_o;
        bus.obi_gnt_i = 1'b1;
        step();
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = mem[idx];
        bus.obi_err_i    = err;
        step();
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready_o); end
        tests++; if (bus.obi_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", bus.obi_req_o); end
        tests++; if (bus.obi_rready_o !== 1'b0) begin fails++; $display("FAIL reset_rready got %b want 0", bus.obi_rready_o); end
        tests++; if (bus.rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid_o); end
        tests++; if (bus.rsp_err_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err_o); end
        tests++; if (bus.rsp_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata_o); end
        tests++; if ({bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o, bus.obi_wdata_o} !== 69'h0) begin
            fails++; $display("FAIL reset_obi_a got %h/%b/%h/%h want 0", bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o, bus.obi_wdata_o); end
        tests++; if (bus.txn_count_o !== 16'h0) begin fails++; $display("FAIL reset_count got %h want 0", bus.txn_count_o); end
        tests++; if (bus.proto_err_o !== 1'b0) begin fails++; $display("FAIL reset_proto got %b want 0", bus.proto_err_o); end
    endtask

    task automatic test_read();
        do_reset();
        mem[1] = 32'hDA7A_5EAD;
        drive_cmd(32'h4, 1'b0, 4'hF, 32'h1234_5678);
        tests++; if (bus.obi_req_o !== 1'b1) begin fails++; $display("FAIL read_req_latency got %b want 1", bus.obi_req_o); end
        tests++; if (bus.cmd_ready_o !== 1'b0) begin fails++; $display("FAIL read_cmd_ready_busy got %b want 0", bus.cmd_ready_o); end
        tests++; if (bus.obi_addr_o !== 32'h4 || bus.obi_we_o !== 1'b0 || bus.obi_be_o !== 4'hF) begin
            fails++; $display("FAIL read_obi_a got %h/%b/%h want 4/0/f", bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o); end
        tests++; if (bus.obi_wdata_o !== 32'h0) begin fails++; $display("FAIL read_wdata_zero got %h want 0", bus.obi_wdata_o); end
        bus.obi_gnt_i = 1'b1;
        step();
        bus.obi_gnt_i = 1'b0;
        tests++; if (bus.obi_req_o !== 1'b0 || bus.obi_rready_o !== 1'b1) begin
            fails++; $display("FAIL read_resp_state got req=%b rready=%b want 0/1", bus.obi_req_o, bus.obi_rready_o); end
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = mem[1];
        step();
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        tests++; if (bus.rsp_valid_o !== 1'b1) begin fails++; $display("FAIL read_rsp_valid got %b want 1", bus.rsp_valid_o); end
        tests++; if (bus.rsp_rdata_o !== 32'hDA7A_5EAD) begin fails++; $display("FAIL read_rdata got %h want da7a5ead", bus.rsp_rdata_o); end
        tests++; if (bus.rsp_err_o !== 1'b0) begin fails++; $display("FAIL read_err got %b want 0", bus.rsp_err_o); end
        tests++; if (bus.obi_rready_o !== 1'b0) begin fails++; $display("FAIL read_rready_done got %b want 0", bus.obi_rready_o); end
        finish_rsp();
        tests++; if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
            fails++; $display("FAIL read_idle got rsp_valid=%b cmd_ready=%b want 0/1", bus.rsp_valid_o, bus.cmd_ready_o); end
        tests++; if (bus.txn_count_o !== 16'd1) begin fails++; $display("FAIL read_count got %0d want 1", bus.txn_count_o); end
        tests++; if (bus.proto_err_o !== 1'b0) begin fails++; $display("FAIL read_proto got %b want 0", bus.proto_err_o); end
    endtask

    task automatic test_write_readback();
        do_reset();
        mem[2] = 32'h0;
        drive_cmd(32'h8, 1'b1, 4'hF, 32'h1337_C0DE);
        tests++; if (bus.obi_we_o !== 1'b1 || bus.obi_wdata_o !== 32'h1337_C0DE || bus.obi_addr_o !== 32'h8) begin
            fails++; $display("FAIL wr_obi_a got we=%b wdata=%h addr=%h want 1/1337c0de/8", bus.obi_we_o, bus.obi_wdata_o, bus.obi_addr_o); end
        serve(1'b0);
        tests++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin
            fails++; $display("FAIL wr_rsp got valid=%b err=%b want 1/0", bus.rsp_valid_o, bus.rsp_err_o); end
        tests++; if (bus.rsp_rdata_o !== 32'h0) begin fails++; $display("FAIL wr_rdata_zero got %h want 0", bus.rsp_rdata_o); end
        finish_rsp();
        drive_cmd(32'h8, 1'b0, 4'hF, 32'h0);
        serve(1'b0);
        tests++; if (bus.rsp_rdata_o !== 32'h1337_C0DE || bus.rsp_err_o !== 1'b0) begin
            fails++; $display("FAIL rb_rdata got %h err=%b want 1337c0de/0", bus.rsp_rdata_o, bus.rsp_err_o); end
        finish_rsp();
        tests++; if (bus.txn_count_o !== 16'd2) begin fails++; $display("FAIL rb_count got %0d want 2", bus.txn_count_o); end
    endtask

    task automatic test_local_error();
        logic saw_req;
        do_reset();
        saw_req = 1'b0;
        drive_cmd(32'h2, 1'b0, 4'hF, 32'h0);
        tests++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1) begin
            fails++; $display("FAIL mis_rsp got valid=%b err=%b want 1/1", bus.rsp_valid_o, bus.rsp_err_o); end
        tests++; if (bus.rsp_rdata_o !== 32'hBADC_AB1E) begin fails++; $display("FAIL mis_rdata got %h want badcab1e", bus.rsp_rdata_o); end
        for (int i = 0; i < 3; i++) begin
            if (bus.obi_req_o !== 1'b0) saw_req = 1'b1;
            step();
        end
        tests++; if (saw_req !== 1'b0) begin fails++; $display("FAIL mis_no_req got %b want 0", saw_req); end
        finish_rsp();
        tests++; if (bus.txn_count_o !== 16'd1) begin fails++; $display("FAIL mis_count got %0d want 1", bus.txn_count_o); end
        drive_cmd(32'h4, 1'b1, 4'h0, 32'h5555_AAAA);
        tests++; if (bus.obi_req_o !== 1'b0 || bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'hBADC_AB1E) begin
            fails++; $display("FAIL be0_rsp got req=%b err=%b rdata=%h want 0/1/badcab1e", bus.obi_req_o, bus.rsp_err_o, bus.rsp_rdata_o); end
        finish_rsp();
        tests++; if (bus.txn_count_o !== 16'd2 || bus.proto_err_o !== 1'b0) begin
            fails++; $display("FAIL be0_count got %0d proto=%b want 2/0", bus.txn_count_o, bus.proto_err_o); end
    endtask

    task automatic test_stall();
        logic moved;
        do_reset();
        moved = 1'b0;
        drive_cmd(32'hC, 1'b1, 4'h5, 32'hA5A5_0F0F);
        for (int i = 0; i < 3; i++) begin
            if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'hC || bus.obi_be_o !== 4'h5 ||
                bus.obi_wdata_o !== 32'hA5A5_0F0F) moved = 1'b1;
            step();
        end
        tests++; if (moved !== 1'b0 || bus.obi_req_o !== 1'b1) begin
            fails++; $display("FAIL stall_addr_frozen got moved=%b req=%b want 0/1", moved, bus.obi_req_o); end
        serve(1'b1);
        for (int i = 0; i < 2; i++) begin
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0 || bus.rsp_err_o !== 1'b1) moved = 1'b1;
            step();
        end
        tests++; if (moved !== 1'b0 || bus.rsp_valid_o !== 1'b1) begin
            fails++; $display("FAIL stall_done_frozen got moved=%b valid=%b want 0/1", moved, bus.rsp_valid_o); end
        tests++; if (bus.txn_count_o !== 16'd0) begin fails++; $display("FAIL stall_count_pending got %0d want 0", bus.txn_count_o); end
        finish_rsp();
        step();
        tests++; if (bus.txn_count_o !== 16'd1) begin fails++; $display("FAIL stall_count got %0d want 1", bus.txn_count_o); end
    endtask

    task automatic test_proto_gnt();
        do_reset();
        bus.obi_gnt_i = 1'b1;
        step();
        bus.obi_gnt_i = 1'b0;
        tests++; if (bus.proto_err_o !== 1'b1) begin fails++; $display("FAIL proto_gnt got %b want 1", bus.proto_err_o); end
        tests++; if (bus.cmd_ready_o !== 1'b1 || bus.obi_rready_o !== 1'b0) begin
            fails++; $display("FAIL proto_gnt_state got cmd_ready=%b rready=%b want 1/0", bus.cmd_ready_o, bus.obi_rready_o); end
        step();
        tests++; if (bus.proto_err_o !== 1'b1) begin fails++; $display("FAIL proto_sticky got %b want 1", bus.proto_err_o); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        drive_cmd(32'h4, 1'b0, 4'hF, 32'h0);
        bus.obi_gnt_i = 1'b1;
        step();
        bus.obi_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (bus.obi_rready_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
            fails++; $display("FAIL rst_resp_idle got rready=%b cmd_ready=%b want 0/1", bus.obi_rready_o, bus.cmd_ready_o); end
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = 32'hDEAD_BEEF;
        step();
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        step();
        tests++; if (bus.proto_err_o !== 1'b1) begin fails++; $display("FAIL rst_late_rvalid_proto got %b want 1", bus.proto_err_o); end
        tests++; if (bus.rsp_valid_o !== 1'b0 || bus.txn_count_o !== 16'd0) begin
            fails++; $display("FAIL rst_no_rsp got valid=%b count=%0d want 0/0", bus.rsp_valid_o, bus.txn_count_o); end
        tests++; if (bus.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL rst_still_idle got %b want 1", bus.cmd_ready_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem[3] = 32'h0BAD_F00D;
        mem[4] = 32'hC0FF_EE00;
        drive_cmd(32'hC, 1'b0, 4'hF, 32'h0);
        serve(1'b0);
        tests++; if (bus.rsp_rdata_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL b2b_first got %h want 0badf00d", bus.rsp_rdata_o); end
        finish_rsp();
        drive_cmd(32'h10, 1'b0, 4'h3, 32'h0);
        tests++; if (bus.obi_addr_o !== 32'h10 || bus.obi_be_o !== 4'h3) begin
            fails++; $display("FAIL b2b_second_a got %h/%h want 10/3", bus.obi_addr_o, bus.obi_be_o); end
        serve(1'b1);
        tests++; if (bus.rsp_rdata_o !== 32'hC0FF_EE00 || bus.rsp_err_o !== 1'b1) begin
            fails++; $display("FAIL b2b_second got %h err=%b want c0ffee00/1", bus.rsp_rdata_o, bus.rsp_err_o); end
        finish_rsp();
        tests++; if (bus.txn_count_o !== 16'd2) begin fails++; $display("FAIL b2b_count got %0d want 2", bus.txn_count_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_read();
        test_write_readback();
        test_local_error();
        test_stall();
        test_proto_gnt();
        test_reset_in_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/obi_manager_bridge.md
OBI_MANAGER_BRIDGE -- requirements
Module: obi_manager_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, OBI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, OBI data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: controller command handshake.
REQ-006 SHALL have ports cmd_addr_i in ADDR_WIDTH, cmd_we_i in 1, cmd_be_i in DATA_WIDTH/8, cmd_wdata_i in DATA_WIDTH: command payload.
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out DATA_WIDTH, rsp_err_o out 1: controller response.
REQ-008 SHALL have ports obi_req_o out 1, obi_gnt_i in 1, obi_addr_o out ADDR_WIDTH, obi_we_o out 1, obi_be_o out DATA_WIDTH/8, obi_wdata_o out DATA_WIDTH: OBI A channel.
REQ-009 SHALL have ports obi_rvalid_i in 1, obi_rready_o out 1, obi_rdata_i in DATA_WIDTH, obi_err_i in 1: OBI R channel.
REQ-010 SHALL have ports txn_count_o out 16 (completed transactions) and proto_err_o out 1 (sticky protocol-violation flag).

Function
REQ-011 SHALL implement FSM IDLE=2'b00, ADDR=2'b01, RESP=2'b10, DONE=2'b11; at most one outstanding transaction.
REQ-012 IDLE: cmd_ready_o=1; all other states cmd_ready_o=0.
REQ-013 IDLE and cmd_valid_i=1: latch addr/we/be/wdata; if cmd_addr_i[1:0]!=0 or cmd_be_i==0, go to DONE with rsp_err_o=1, rsp_rdata_o=32'hBADCAB1E, no OBI request issued; else go to ADDR.
REQ-014 ADDR: obi_req_o=1; obi_addr_o/we/be/wdata driven from latched values, stable until grant; obi_wdata_o=0 for reads.
REQ-015 ADDR and obi_gnt_i=1: go to RESP next cycle; obi_req_o deasserts in that cycle.
REQ-016 RESP: obi_rready_o=1; all other states obi_rready_o=0.
REQ-017 RESP and obi_rvalid_i=1: capture rsp_rdata_o=obi_rdata_i for reads (0 for writes), rsp_err_o=obi_err_i; go to DONE.
REQ-018 DONE: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; on rsp_ready_i=1 go to IDLE and increment txn_count_o (mod 2^16, wraps FFFF->0000).
REQ-019 Locally-errored commands (REQ-013) also increment txn_count_o on completion.
REQ-020 Best-case latency: command accepted cycle N; obi_req_o=1 cycle N+1; gnt in N+1; rvalid in N+2; rsp_valid_o=1 cycle N+3.
REQ-021 obi_rvalid_i=1 outside RESP, or obi_gnt_i=1 outside ADDR, SHALL set proto_err_o=1 (sticky until reset) and be otherwise ignored.
REQ-022 All outputs SHALL be registered or decoded from state/registers only; no combinational path from OBI inputs to OBI outputs.
REQ-023 Wait states: gnt held low any number of cycles keeps FSM in ADDR with outputs frozen; rsp_ready_i low keeps DONE indefinitely.

Reset
REQ-024 reset_i=1 at a rising edge SHALL force state IDLE, obi_req_o=0, obi_rready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, obi_addr_o/we/be/wdata=0, txn_count_o=0, proto_err_o=0; cmd_ready_o=1 once reset deasserts.
REQ-025 Reset mid-transaction (any state) SHALL abandon it: no response delivered, count not incremented; late obi_rvalid_i after reset sets proto_err_o.

Verification
REQ-026 Read: slave preloaded 0x4=DA7A5EAD; cmd addr 0x4, we=0, be=4'hF -> obi_req_o one cycle after accept, rsp_rdata_o=DA7A5EAD, rsp_err_o=0, txn_count_o=1.
REQ-027 Write/readback: write 0x8 data 1337C0DE be=4'hF, then read 0x8 -> read returns 1337C0DE, both rsp_err_o=0, txn_count_o=2.
REQ-028 Misaligned: cmd addr 0x2 -> obi_req_o never asserts, rsp_valid_o with rsp_err_o=1, rsp_rdata_o=BADCAB1E.
REQ-029 Stall: gnt withheld 3 cycles, rsp_ready_i low 2 cycles -> obi_addr_o/be/wdata unchanged during ADDR, rsp payload unchanged during DONE, single completion counted.
REQ-030 Reset in RESP then spurious rvalid -> state IDLE, rsp_valid_o=0, txn_count_o=0, proto_err_o=1.
